// File: rtl/linked_list.sv
// Shared types for the linked-list engine and its head-table initiator.
package linked_list;

   localparam int LL_KEY_WIDTH       = 16;
   localparam int LL_HEAD_PTR_WIDTH  = 10;
   localparam int LL_HT_BUCKET_WIDTH = 8;

   typedef logic [1:0] ll_opcode_t;
   typedef logic [2:0] ll_rescode_t;
   typedef logic [2:0] ll_chain_state_t;

   localparam ll_opcode_t LL_OP_INSERT = 2'd0;
   localparam ll_opcode_t LL_OP_DELETE = 2'd1;
   localparam ll_opcode_t LL_OP_DEQ    = 2'd2;

   typedef logic [LL_HT_BUCKET_WIDTH-1:0] ll_ht_bucket_t;

   typedef struct packed {
      logic                         val;
      logic [LL_HEAD_PTR_WIDTH-1:0] ptr;
   } ll_head_entry_t;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      RD,
      CMD,
      WAIT,
      RESP
   } ll_ht_ctrl_state_t;

   function automatic logic ll_op_known(input ll_opcode_t op);
      return op inside {LL_OP_INSERT, LL_OP_DELETE, LL_OP_DEQ};
   endfunction

endpackage

// File: rtl/ll_head_ram.sv
// Simple dual-port head-pointer RAM: registered read, write-first on
// a same-address collision.
module ll_head_ram #(
   parameter int AW = 8,
   parameter int DW = 11
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i
                                                  : mem[raddr_i];
      end
   end

endmodule

// File: rtl/ll_head_table_ctrl.sv
// Head-pointer table initiator for the linked-list engine.
// Define LL_HT_STATS_EN to add the command / non-empty bucket counters.
module ll_head_table_ctrl
   import linked_list::*;
#(
   parameter int BUCKET_WIDTH = LL_HT_BUCKET_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [LL_KEY_WIDTH-1:0]      req_key_i,
   input  logic [1:0]                   req_opcode_i,
   input  logic [BUCKET_WIDTH-1:0]      req_bucket_i,
   output logic                         ll_cmd_valid_o,
   input  logic                         ll_cmd_ready_i,
   output logic [LL_KEY_WIDTH-1:0]      ll_cmd_key_o,
   output logic [1:0]                   ll_cmd_opcode_o,
   output logic [LL_HEAD_PTR_WIDTH-1:0] ll_cmd_head_ptr_o,
   output logic                         ll_cmd_head_ptr_val_o,
   input  logic                         ll_res_valid_i,
   output logic                         ll_res_ready_o,
   input  logic [LL_KEY_WIDTH-1:0]      ll_res_key_i,
   input  logic [1:0]                   ll_res_opcode_i,
   input  logic [2:0]                   ll_res_rescode_i,
   input  logic [2:0]                   ll_res_chain_state_i,
   input  logic [LL_HEAD_PTR_WIDTH-1:0] ht_wr_data_ptr_i,
   input  logic                         ht_wr_data_ptr_val_i,
   input  logic                         ht_wr_en_i,
   output logic                         resp_valid_o,
   input  logic                         resp_ready_i,
   output logic [LL_KEY_WIDTH-1:0]      resp_key_o,
   output logic [1:0]                   resp_opcode_o,
   output logic [2:0]                   resp_rescode_o,
   output logic [2:0]                   resp_chain_state_o,
   output logic                         drop_o,
`ifdef LL_HT_STATS_EN
   output logic [31:0]                  stat_cmd_cnt_o,
   output logic [BUCKET_WIDTH:0]        stat_nonempty_o,
`endif
   input  logic                         clear_run_i,
   output logic                         clear_done_o
);

   localparam int EW = LL_HEAD_PTR_WIDTH + 1;

   ll_ht_ctrl_state_t         state;
   logic [BUCKET_WIDTH-1:0]   clr_addr;
   logic [BUCKET_WIDTH-1:0]   bucket_q;
   logic                      clear_pend;
   logic                      rdy_q;

   ll_head_entry_t            rd_q;
   ll_head_entry_t            wr_d;
   logic [BUCKET_WIDTH-1:0]   wr_addr;
   logic                      wr_en;
   logic                      rd_en;
   logic                      wb;
   logic                      op_ok;

   assign op_ok       = ll_op_known(req_opcode_i);
   assign req_ready_o = rdy_q & ~clear_run_i;
   assign rd_en       = (state == IDLE) & req_valid_i & req_ready_o & op_ok;
   assign wb          = (state == WAIT) & ll_res_valid_i;

   // Write port is owned by the sweep in CLEAR, by write-back otherwise.
   assign wr_en   = (state == CLEAR) | (wb & ht_wr_en_i);
   assign wr_addr = (state == CLEAR) ? clr_addr : bucket_q;
   assign wr_d    = (state == CLEAR) ? '0
                  : {ht_wr_data_ptr_val_i, ht_wr_data_ptr_i};

   assign clear_done_o = (state == CLEAR) & (clr_addr == '1);

   ll_head_ram #(
      .AW (BUCKET_WIDTH),
      .DW (EW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (wr_d),
      .re_i    (rd_en),
      .raddr_i (req_bucket_i),
      .rdata_o (rd_q)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state                 <= CLEAR;
         clr_addr              <= '0;
         bucket_q              <= '0;
         clear_pend            <= 1'b0;
         rdy_q                 <= 1'b0;
         ll_cmd_valid_o        <= 1'b0;
         ll_cmd_key_o          <= '0;
         ll_cmd_opcode_o       <= '0;
         ll_cmd_head_ptr_o     <= '0;
         ll_cmd_head_ptr_val_o <= 1'b0;
         ll_res_ready_o        <= 1'b0;
         resp_valid_o          <= 1'b0;
         resp_key_o            <= '0;
         resp_opcode_o         <= '0;
         resp_rescode_o        <= '0;
         resp_chain_state_o    <= '0;
         drop_o                <= 1'b0;
      end else begin
         drop_o <= 1'b0;
         if (clear_run_i && (state != IDLE)) begin
            clear_pend <= 1'b1;
         end
         unique case (state)
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == '1) begin
                  if (clear_pend || clear_run_i) begin
                     clear_pend <= 1'b0;
                  end else begin
                     state <= IDLE;
                     rdy_q <= 1'b1;
                  end
               end
            end
            IDLE: begin
               if (clear_run_i) begin
                  state <= CLEAR;
                  rdy_q <= 1'b0;
               end else if (req_valid_i && rdy_q) begin
                  if (op_ok) begin
                     bucket_q        <= req_bucket_i;
                     ll_cmd_key_o    <= req_key_i;
                     ll_cmd_opcode_o <= req_opcode_i;
                     rdy_q           <= 1'b0;
                     state           <= RD;
                  end else begin
                     drop_o <= 1'b1;
                  end
               end
            end
            RD: begin
               ll_cmd_head_ptr_o     <= rd_q.ptr;
               ll_cmd_head_ptr_val_o <= rd_q.val;
               ll_cmd_valid_o        <= 1'b1;
               state                 <= CMD;
            end
            CMD: begin
               if (ll_cmd_ready_i) begin
                  ll_cmd_valid_o <= 1'b0;
                  ll_res_ready_o <= 1'b1;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (ll_res_valid_i) begin
                  resp_key_o         <= ll_res_key_i;
                  resp_opcode_o      <= ll_res_opcode_i;
                  resp_rescode_o     <= ll_res_rescode_i;
                  resp_chain_state_o <= ll_res_chain_state_i;
                  ll_res_ready_o     <= 1'b0;
                  resp_valid_o       <= 1'b1;
                  state              <= RESP;
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  if (clear_pend || clear_run_i) begin
                     clear_pend <= 1'b0;
                     state      <= CLEAR;
                  end else begin
                     rdy_q <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

`ifdef LL_HT_STATS_EN
   localparam logic [BUCKET_WIDTH:0] NE_ONE = (BUCKET_WIDTH+1)'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_cmd_cnt_o  <= '0;
         stat_nonempty_o <= '0;
      end else begin
         if ((state == CMD) && ll_cmd_ready_i) begin
            stat_cmd_cnt_o <= stat_cmd_cnt_o + 32'd1;
         end
         // Old occupancy is the head value captured in RD for this bucket.
         if (state == CLEAR) begin
            stat_nonempty_o <= '0;
         end else if (wb && ht_wr_en_i) begin
            if (!ll_cmd_head_ptr_val_o && ht_wr_data_ptr_val_i) begin
               stat_nonempty_o <= stat_nonempty_o + NE_ONE;
            end else if (ll_cmd_head_ptr_val_o && !ht_wr_data_ptr_val_i) begin
               stat_nonempty_o <= stat_nonempty_o - NE_ONE;
            end
         end
      end
   end
`endif

endmodule
